// File: rtl/mm_responder.sv
// Line-burst memory responder: accepts one cache-line read or write at a time
// and streams WORDS_PER_LINE single-cycle beats after a fixed start latency.
module mm_responder #(
   parameter int WORDS_PER_LINE = 4,
   parameter int DEPTH          = 1024,
   parameter int LATENCY        = 4,
   parameter int BEAT_GAP       = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        re_mm,
   input  logic        we_mm,
   input  logic [31:0] addr_mm,
   input  logic [31:0] wdata_mm,
   output logic [31:0] rdata_mm,
   output logic        mem_valid_mm,
   output logic        busy
);

   localparam int AW   = $clog2(DEPTH);
   localparam int IW   = $clog2(WORDS_PER_LINE);
   localparam int CMAX = (LATENCY > BEAT_GAP) ? LATENCY : BEAT_GAP;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

   localparam logic [AW-1:0] LINE_MASK = ~(AW'(WORDS_PER_LINE - 1));
   localparam logic [CW-1:0] LAT_LAST  = CW'(LATENCY - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(BEAT_GAP - 1);
   localparam logic [IW-1:0] IDX_LAST  = {IW{1'b1}};

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT, S_GAP} state_t;

   state_t        state_q, state_d;
   logic          op_wr_q, op_wr_d;
   logic [AW-1:0] base_q, base_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          req_live;
   logic          beat_fire;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr_d;
   logic [31:0]   rd_data_q;
   logic [31:0]   mem [DEPTH];

   logic          unused_addr_bits;
   assign unused_addr_bits = ^{addr_mm[31:AW+2], addr_mm[1:0]};

   // Only the request line that opened the burst keeps it alive; an op swap aborts.
   assign req_live  = op_wr_q ? we_mm : re_mm;
   assign beat_fire = (state_q == S_BEAT) && req_live;
   assign wr_en     = beat_fire && op_wr_q && !reset;
   assign wr_addr   = base_q + AW'(idx_q);

   always_comb begin
      state_d = state_q;
      op_wr_d = op_wr_q;
      base_d  = base_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (re_mm || we_mm) begin
               op_wr_d = we_mm;
               base_d  = addr_mm[AW+1:2] & LINE_MASK;
               idx_d   = '0;
               cnt_d   = '0;
               state_d = (LATENCY > 0) ? S_WAIT : S_BEAT;
            end
         end
         S_WAIT: begin
            if (!req_live) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == LAT_LAST) begin
               state_d = S_BEAT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_BEAT: begin
            if (!req_live) begin
               state_d = S_IDLE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 1'b1;
               if (idx_q == IDX_LAST) begin
                  state_d = S_IDLE;
               end else if (BEAT_GAP > 0) begin
                  state_d = S_GAP;
                  cnt_d   = '0;
               end else begin
                  state_d = S_BEAT;
               end
            end
         end
         S_GAP: begin
            if (!req_live) begin
               state_d = S_IDLE;
               idx_d   = '0;
               cnt_d   = '0;
            end else if (cnt_q == GAP_LAST) begin
               state_d = S_BEAT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Read port looks one cycle ahead so the word is ready when the beat opens.
   assign rd_addr_d = base_d + AW'(idx_d);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_wr_q <= 1'b0;
         base_q  <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_wr_q <= op_wr_d;
         base_q  <= base_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wdata_mm;
      end
      rd_data_q <= mem[rd_addr_d];
   end

   assign mem_valid_mm = beat_fire;
   assign rdata_mm     = (beat_fire && !op_wr_q) ? rd_data_q : 32'd0;
   assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_mm_responder.sv
// Randomized bench for mm_responder: three instances with different latency/gap
// settings, each checked cycle by cycle against a timeline-and-array model.
module tb_mm_responder;

   localparam int NI    = 3;
   localparam int W     = 4;
   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst   [NI];
   logic        re    [NI];
   logic        we    [NI];
   logic [31:0] addr  [NI];
   logic [31:0] wdata [NI];
   logic [31:0] rdata [NI];
   logic        valid [NI];
   logic        busy  [NI];

   logic [31:0] model [NI][DEPTH];
   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   generate
      for (genvar gi = 0; gi < NI; gi++) begin : g_dut
         mm_responder #(
            .WORDS_PER_LINE(W),
            .DEPTH         (DEPTH),
            .LATENCY       ((gi == 2) ? 0 : 4),
            .BEAT_GAP      (gi)
         ) u_dut (
            .clk         (clk),
            .reset       (rst[gi]),
            .re_mm       (re[gi]),
            .we_mm       (we[gi]),
            .addr_mm     (addr[gi]),
            .wdata_mm    (wdata[gi]),
            .rdata_mm    (rdata[gi]),
            .mem_valid_mm(valid[gi]),
            .busy        (busy[gi])
         );
      end
   endgenerate

   function automatic int lat_of(input int k);
      return (k == 2) ? 0 : 4;
   endfunction

   function automatic int gap_of(input int k);
      return k;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int k);
      rst[k]   = 1'b0;
      re[k]    = 1'b0;
      we[k]    = 1'b0;
      addr[k]  = $urandom;
      wdata[k] = $urandom;
      @(negedge clk);
      check_eq($sformatf("u%0d idle valid", k), {31'd0, valid[k]}, 32'd0);
      check_eq($sformatf("u%0d idle busy", k), {31'd0, busy[k]}, 32'd0);
      check_eq($sformatf("u%0d idle rdata", k), rdata[k], 32'd0);
      next_cycle();
   endtask

   // Reset asserted while a write request is already high.
   task automatic reset_hold(input int k, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         rst[k]   = 1'b1;
         we[k]    = 1'b1;
         re[k]    = 1'b0;
         addr[k]  = $urandom;
         wdata[k] = $urandom;
         @(negedge clk);
         check_eq($sformatf("u%0d rsthold valid", k), {31'd0, valid[k]}, 32'd0);
         check_eq($sformatf("u%0d rsthold busy", k), {31'd0, busy[k]}, 32'd0);
         next_cycle();
      end
      $display("u%0d reset held %0d cycles with we_mm high", k, cycles);
   endtask

   // One transaction from its acceptance cycle up to (not including) the IDLE cycle
   // that follows it. abort_n < W drops the request right after beat abort_n-1;
   // rst_beat >= 0 pulses reset during that beat.
   task automatic run_txn(input int k, input bit wr, input logic [31:0] a,
                          input int abort_n, input int rst_beat);
      int lat, gap, base, first, last, drop_c, rst_c, end_c, j, wa, nbeats;
      bit live, beat;
      logic [31:0] exp_rd;
      lat    = lat_of(k);
      gap    = gap_of(k);
      base   = int'(a[11:2]) & ~(W - 1);
      first  = lat + 1;
      last   = first + (W - 1) * (gap + 1);
      drop_c = (abort_n >= W) ? -1 : ((abort_n == 0) ? 1 : first + (abort_n - 1) * (gap + 1) + 1);
      rst_c  = (rst_beat >= 0) ? first + rst_beat * (gap + 1) : -1;
      end_c  = (drop_c >= 0) ? drop_c + 1 : ((rst_c >= 0) ? rst_c + 1 : last + 1);
      nbeats = 0;
      for (int c = 0; c < end_c; c++) begin
         live     = (drop_c < 0) || (c < drop_c);
         rst[k]   = (c == rst_c);
         if (wr) begin
            we[k] = live;
            re[k] = (c == drop_c) ? 1'($urandom_range(0, 1)) : 1'b0;
         end else begin
            re[k] = live;
            we[k] = (c == drop_c) ? 1'($urandom_range(0, 1)) : 1'b0;
         end
         addr[k]  = (c == 0) ? a : $urandom;
         wdata[k] = $urandom;
         j    = (c >= first) ? (c - first) / (gap + 1) : 0;
         beat = (c >= first) && (((c - first) % (gap + 1)) == 0) && (j < W) && live;
         wa   = (base + j) % DEPTH;
         exp_rd = (beat && !wr) ? model[k][wa] : 32'd0;
         @(negedge clk);
         check_eq($sformatf("u%0d c%0d valid", k, c), {31'd0, valid[k]}, {31'd0, beat});
         check_eq($sformatf("u%0d c%0d busy", k, c), {31'd0, busy[k]}, (c > 0) ? 32'd1 : 32'd0);
         check_eq($sformatf("u%0d c%0d rdata", k, c), rdata[k], exp_rd);
         if (beat) begin
            nbeats++;
            if (wr && (c != rst_c)) model[k][wa] = wdata[k];
         end
         next_cycle();
      end
      $display("u%0d %s addr=%h beats=%0d abort=%0d rst_beat=%0d cycles=%0d",
               k, wr ? "WR" : "RD", a, nbeats, abort_n, rst_beat, end_c);
   endtask

   function automatic logic [31:0] rand_addr();
      int line;
      line = $urandom_range(0, 8);
      if (line == 8) line = DEPTH / W - 1;
      return ($urandom & 32'hFFFF_F000) | (32'(line) << 4) | 32'($urandom_range(0, 15));
   endfunction

   initial begin
      bit wr;
      int abort_n;
      for (int k = 0; k < NI; k++) begin
         rst[k] = 1'b1;
         re[k] = 1'b0;
         we[k] = 1'b0;
         addr[k] = 32'd0;
         wdata[k] = 32'd0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
         check_eq($sformatf("u%0d reset valid", k), {31'd0, valid[k]}, 32'd0);
         check_eq($sformatf("u%0d reset busy", k), {31'd0, busy[k]}, 32'd0);
         check_eq($sformatf("u%0d reset rdata", k), rdata[k], 32'd0);
         rst[k] = 1'b0;
      end
      next_cycle();

      for (int k = 0; k < NI; k++) begin
         for (int l = 0; l < 8; l++) run_txn(k, 1'b1, 32'(l) << 4, W, -1);
         run_txn(k, 1'b1, 32'h0000_0FF0, W, -1);
         idle(k);
         run_txn(k, 1'b0, 32'h0000_0014, W, -1);
         idle(k);
         run_txn(k, 1'b1, 32'h0000_0020, W, -1);
         run_txn(k, 1'b0, 32'h0000_0040, W, -1);
         idle(k);
         run_txn(k, 1'b0, 32'h0000_0010, 2, -1);
         idle(k);
         run_txn(k, 1'b0, 32'h0000_0010, W, -1);
         run_txn(k, 1'b1, 32'h0000_0030, W, 2);
         idle(k);
         run_txn(k, 1'b0, 32'h0000_0030, W, -1);
         reset_hold(k, 2);
         run_txn(k, 1'b1, 32'h0000_1000, W, -1);
         run_txn(k, 1'b0, 32'h0000_0000, W, -1);
         run_txn(k, 1'b0, 32'h0000_0FF0, W, -1);
         idle(k);
         for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom_range(0, 1));
            abort_n = ($urandom_range(0, 4) == 0) ? $urandom_range(0, W - 1) : W;
            run_txn(k, wr, rand_addr(), abort_n, -1);
            if ($urandom_range(0, 1) == 1) idle(k);
         end
         idle(k);
         for (int l = 0; l < 8; l++) run_txn(k, 1'b0, 32'(l) << 4, W, -1);
         run_txn(k, 1'b0, 32'h0000_0FF0, W, -1);
         idle(k);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
